// File: rtl/ccir656_timing_ctrl.sv
// BT.656 (525-line) byte-stream sequencer: line/byte counters, EAV/SAV codes, blanking fill, active fetch.
// Optional CCIR656_CLAMP_EN: clamp captured active bytes away from the reserved 0x00/0xFF codes.
module ccir656_timing_ctrl #(
    parameter int LINE_BYTES   = 1716,
    parameter int ACTIVE_BYTES = 1440,
    parameter int FRAME_LINES  = 525
) (
    input  logic       clk27M,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] px_data,
    output logic       px_req,
    output logic [7:0] data,
    output logic [9:0] line_num,
    output logic       field,
    output logic       vblank,
    output logic       sof,
    output logic       led
);

    localparam int BW = $clog2(LINE_BYTES);
    localparam logic [BW-1:0] EAV_LAST_C  = BW'(3);
    localparam logic [BW-1:0] SAV_FIRST_C = BW'(LINE_BYTES - ACTIVE_BYTES - 4);
    localparam logic [BW-1:0] HB_LAST_C   = BW'(LINE_BYTES - ACTIVE_BYTES - 5);
    localparam logic [BW-1:0] SAV_LAST_C  = BW'(LINE_BYTES - ACTIVE_BYTES - 1);
    localparam logic [BW-1:0] B_LAST_C    = BW'(LINE_BYTES - 1);
    localparam logic [9:0]    LAST_LINE_C = 10'(FRAME_LINES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EAV,
        ST_HBLANK,
        ST_SAV,
        ST_ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] b_q, b_d;
    logic [9:0]    ln_q, ln_d;
    logic [9:0]    line_num_q, line_num_d;
    logic          field_q, field_d;
    logic          vblank_q, vblank_d;
    logic          sof_q, sof_d;
    logic          led_q, led_d;
    logic          px_req_q, px_req_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    px_cap;
    logic [1:0]    sav_idx;

    function automatic logic field_of(input logic [9:0] ln);
        return (ln <= 10'd3) || (ln >= 10'd266);
    endfunction

    function automatic logic vblank_of(input logic [9:0] ln);
        return (ln <= 10'd19) || ((ln >= 10'd264) && (ln <= 10'd282));
    endfunction

    // Timing reference code: FF 00 00 XY, XY carrying the Hamming protection bits.
    function automatic logic [7:0] trs_byte(input logic [1:0] idx, input logic f,
                                            input logic v, input logic h);
        case (idx)
            2'd0:    return 8'hFF;
            2'd1:    return 8'h00;
            2'd2:    return 8'h00;
            default: return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        endcase
    endfunction

    function automatic logic [7:0] fill_byte(input logic odd);
        return odd ? 8'h10 : 8'h80;
    endfunction

    always_comb begin
`ifdef CCIR656_CLAMP_EN
        if (px_data == 8'hFF) begin
            px_cap = 8'hFE;
        end else if (px_data == 8'h00) begin
            px_cap = 8'h01;
        end else begin
            px_cap = px_data;
        end
`else
        px_cap = px_data;
`endif
    end

    assign sav_idx = 2'(b_q - SAV_FIRST_C);

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        ln_d       = ln_q;
        line_num_d = line_num_q;
        field_d    = field_q;
        vblank_d   = vblank_q;
        sof_d      = 1'b0;
        led_d      = led_q;
        data_d     = 8'h10;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_EAV;
                    b_d     = '0;
                    ln_d    = 10'd1;
                end
            end
            ST_EAV: begin
                data_d = trs_byte(b_q[1:0], field_q, vblank_q, 1'b1);
                // Line-level outputs switch on the edge that emits the EAV 0xFF.
                if (b_q == '0) begin
                    line_num_d = ln_q;
                    field_d    = field_of(ln_q);
                    vblank_d   = vblank_of(ln_q);
                    sof_d      = (ln_q == 10'd1);
                    led_d      = led_q ^ (ln_q == 10'd1);
                end
                b_d = b_q + 1'b1;
                if (b_q == EAV_LAST_C) begin
                    state_d = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                data_d = fill_byte(b_q[0]);
                b_d    = b_q + 1'b1;
                if (b_q == HB_LAST_C) begin
                    state_d = ST_SAV;
                end
            end
            ST_SAV: begin
                data_d = trs_byte(sav_idx, field_q, vblank_q, 1'b0);
                b_d    = b_q + 1'b1;
                if (b_q == SAV_LAST_C) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                data_d = vblank_q ? fill_byte(b_q[0]) : px_cap;
                if (b_q == B_LAST_C) begin
                    b_d = '0;
                    if (en) begin
                        state_d = ST_EAV;
                        ln_d    = (ln_q == LAST_LINE_C) ? 10'd1 : ln_q + 10'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                b_d     = '0;
            end
        endcase
        // Registered one slot ahead so the request lines up with the slot being decoded.
        px_req_d = (state_d == ST_ACTIVE) && !vblank_q;
    end

    always_ff @(posedge clk27M) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            ln_q       <= 10'd1;
            line_num_q <= 10'd1;
            field_q    <= 1'b1;
            vblank_q   <= 1'b1;
            sof_q      <= 1'b0;
            led_q      <= 1'b0;
            px_req_q   <= 1'b0;
            data_q     <= 8'h10;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            ln_q       <= ln_d;
            line_num_q <= line_num_d;
            field_q    <= field_d;
            vblank_q   <= vblank_d;
            sof_q      <= sof_d;
            led_q      <= led_d;
            px_req_q   <= px_req_d;
            data_q     <= data_d;
        end
    end

    assign px_req   = px_req_q;
    assign data     = data_q;
    assign line_num = line_num_q;
    assign field    = field_q;
    assign vblank   = vblank_q;
    assign sof      = sof_q;
    assign led      = led_q;

endmodule

// File: tb/tb_ccir656_timing_ctrl.sv
// Directed bench for ccir656_timing_ctrl; short lines (64 bytes, 40 active) keep a 525-line frame fast.
`timescale 1ns/1ps
module tb_ccir656_timing_ctrl;

    localparam int LB = 64;
    localparam int AB = 40;
    localparam int AS = LB - AB;
    localparam int SS = AS - 4;
`ifdef CCIR656_CLAMP_EN
    localparam logic [7:0] CLAMP_HI_EXP = 8'hFE;
    localparam logic [7:0] CLAMP_LO_EXP = 8'h01;
`else
    localparam logic [7:0] CLAMP_HI_EXP = 8'hFF;
    localparam logic [7:0] CLAMP_LO_EXP = 8'h00;
`endif

    logic       clk27M = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] px_data;
    logic [7:0] px_prev;
    logic       px_req;
    logic [7:0] data;
    logic [9:0] line_num;
    logic       field;
    logic       vblank;
    logic       sof;
    logic       led;

    int n_cmp = 0;
    int n_err = 0;
    bit led_exp = 1'b0;
    bit clamp_test = 1'b0;

    ccir656_timing_ctrl #(
        .LINE_BYTES  (LB),
        .ACTIVE_BYTES(AB),
        .FRAME_LINES (525)
    ) dut (
        .clk27M  (clk27M),
        .rst     (rst),
        .en      (en),
        .px_data (px_data),
        .px_req  (px_req),
        .data    (data),
        .line_num(line_num),
        .field   (field),
        .vblank  (vblank),
        .sof     (sof),
        .led     (led)
    );

    always #5 clk27M = ~clk27M;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        px_prev = px_data;
        @(posedge clk27M);
        #1;
        px_data = px_data + 8'd1;
    endtask

    function automatic bit exp_field(input int ln);
        return (ln <= 3) || (ln >= 266);
    endfunction

    function automatic bit exp_vblank(input int ln);
        return (ln <= 19) || (ln >= 264 && ln <= 282);
    endfunction

    // XY values taken straight from the BT.656 code table.
    function automatic logic [7:0] xy_code(input bit f, input bit v, input bit h);
        case ({f, v})
            2'b00:   return h ? 8'h9D : 8'h80;
            2'b01:   return h ? 8'hB6 : 8'hAB;
            2'b10:   return h ? 8'hDA : 8'hC7;
            default: return h ? 8'hF1 : 8'hEC;
        endcase
    endfunction

    function automatic logic [7:0] exp_clamp(input logic [7:0] x);
`ifdef CCIR656_CLAMP_EN
        if (x == 8'hFF) return 8'hFE;
        if (x == 8'h00) return 8'h01;
`endif
        return x;
    endfunction

    function automatic logic [7:0] code_byte(input int idx, input bit f, input bit v, input bit h);
        if (idx == 0) return 8'hFF;
        if (idx == 3) return xy_code(f, v, h);
        return 8'h00;
    endfunction

    // Precondition: data currently shows byte 0 of line ln. Checks bytes 0..stop_at-1.
    task automatic run_line(input int ln, input int drop_at, input int stop_at);
        bit f;
        bit v;
        int nreq;
        logic [7:0] exp;
        f    = exp_field(ln);
        v    = exp_vblank(ln);
        nreq = 0;
        for (int k = 0; k < stop_at; k++) begin
            if (k < 4)        exp = code_byte(k, f, v, 1'b1);
            else if (k < SS)  exp = (k % 2 == 1) ? 8'h10 : 8'h80;
            else if (k < AS)  exp = code_byte(k - SS, f, v, 1'b0);
            else if (v)       exp = (k % 2 == 1) ? 8'h10 : 8'h80;
            else              exp = exp_clamp(px_prev);
            check_eq($sformatf("L%0d_b%0d_data", ln, k), 32'(data), 32'(exp));
            if (k == 0) begin
                if (ln == 1) led_exp = ~led_exp;
                check_eq($sformatf("L%0d_line_num", ln), 32'(line_num), 32'(ln));
                check_eq($sformatf("L%0d_field", ln), 32'(field), 32'(f));
                check_eq($sformatf("L%0d_vblank", ln), 32'(vblank), 32'(v));
                check_eq($sformatf("L%0d_led", ln), 32'(led), 32'(led_exp));
            end
            check_eq($sformatf("L%0d_b%0d_sof", ln, k), 32'(sof), 32'(k == 0 && ln == 1));
            check_eq($sformatf("L%0d_b%0d_px_req", ln, k), 32'(px_req),
                     32'(!v && (k + 1 >= AS) && (k + 1 < LB)));
            if (clamp_test && k == AS)
                check_eq("clamp_hi", 32'(data), 32'(CLAMP_HI_EXP));
            if (clamp_test && k == AS + 1)
                check_eq("clamp_lo", 32'(data), 32'(CLAMP_LO_EXP));
            if (px_req) nreq++;
            if (k == drop_at) en = 1'b0;
            if (clamp_test && k == AS - 1) px_data = 8'hFF;
            tick();
        end
        if (stop_at == LB)
            check_eq($sformatf("L%0d_px_req_count", ln), 32'(nreq), 32'(v ? 0 : AB));
        $display("line %0d: %0d bytes checked, %0d requests", ln, stop_at, nreq);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        px_data = 8'h00;
        px_prev = 8'h00;
        tick();
        tick();
        // Reset held with en high: reset dominates.
        check_eq("rst_data", 32'(data), 32'h10);
        check_eq("rst_px_req", 32'(px_req), 32'd0);
        check_eq("rst_line_num", 32'(line_num), 32'd1);
        check_eq("rst_field", 32'(field), 32'd1);
        check_eq("rst_vblank", 32'(vblank), 32'd1);
        check_eq("rst_sof", 32'(sof), 32'd0);
        check_eq("rst_led", 32'(led), 32'd0);

        rst = 1'b0;
        en  = 1'b0;
        tick();
        check_eq("idle_data", 32'(data), 32'h10);
        check_eq("idle_px_req", 32'(px_req), 32'd0);

        en = 1'b1;
        tick();
        check_eq("start_lat_data", 32'(data), 32'h10);
        tick();

        // Full frame plus the wrap into the next frame, dropping en on line 30.
        for (int ln = 1; ln <= 525; ln++) run_line(ln, -1, LB);
        for (int ln = 1; ln <= 29; ln++) run_line(ln, -1, LB);
        run_line(30, 30, LB);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("post_drop%0d_data", i), 32'(data), 32'h10);
            check_eq($sformatf("post_drop%0d_px_req", i), 32'(px_req), 32'd0);
            tick();
        end

        en = 1'b1;
        tick();
        check_eq("restart_lat_data", 32'(data), 32'h10);
        tick();
        for (int ln = 1; ln <= 39; ln++) run_line(ln, -1, LB);
        run_line(40, -1, 30);
        check_eq("pre_rst_px_req", 32'(px_req), 32'd1);

        rst = 1'b1;
        tick();
        led_exp = 1'b0;
        check_eq("midrst_px_req", 32'(px_req), 32'd0);
        check_eq("midrst_data", 32'(data), 32'h10);
        check_eq("midrst_line_num", 32'(line_num), 32'd1);
        check_eq("midrst_field", 32'(field), 32'd1);
        check_eq("midrst_vblank", 32'(vblank), 32'd1);
        check_eq("midrst_led", 32'(led), 32'd0);

        rst = 1'b0;
        tick();
        check_eq("after_rst_data", 32'(data), 32'h10);
        tick();
        for (int ln = 1; ln <= 19; ln++) run_line(ln, -1, LB);
        clamp_test = 1'b1;
        run_line(20, -1, LB);
        clamp_test = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ccir656_timing_ctrl.md
# ccir656_timing_ctrl

Frame/line sequencer for the CCIR656 (BT.656, 525-line) byte stream generator. Owns the byte and line counters, sets F/V/H and emits EAV/SAV timing codes with protection bits and horizontal blanking fill. Fetches active-video bytes from an upstream pixel source through a request strobe, and drives the 8-bit 27 MHz output bus.

## Interface
- `LINE_BYTES`, 1716: bytes per line (EAV + blanking + SAV + active).
- `ACTIVE_BYTES`, 1440: active-video bytes per line.
- `FRAME_LINES`, 525: lines per frame.
- `clk27M`  in  1  byte clock, 27 MHz.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `en`  in  1  run enable.
- `px_data`  in  8  active-video byte from source; sampled on the edge where `px_req`=1.
- `px_req`  out  1  request for one active byte this cycle.
- `data`  out  8  CCIR656 output byte, registered.
- `line_num`  out  10  current line, 1..525.
- `field`  out  1  F bit of current line.
- `vblank`  out  1  V bit of current line.
- `sof`  out  1  one-cycle pulse, coincident with `data`=0xFF of line 1 EAV.
- `led`  out  1  toggles once per frame (at each `sof`).

## Operation
- States: IDLE, EAV, HBLANK, SAV, ACTIVE. Byte counter `b` runs 0..1715 within a line.
  - EAV: b=0..3.
  - HBLANK: b=4..271.
  - SAV: b=272..275.
  - ACTIVE: b=276..1715.
- IDLE → EAV (line 1, b=0) on the first cycle `en`=1. `en` is sampled only at b=1715.
  - If `en`=1 at b=1715: next line starts.
  - If `en`=0 at b=1715: go to IDLE. Resuming always restarts at line 1.
  - Deasserting `en` mid-line never truncates the line.
- Line wrap: 525 → 1.
- F/V are computed from `line_num` at b=0 and held for the whole line.
  - F=1 on lines 1–3 and 266–525; F=0 otherwise.
  - V=1 on lines 1–19 and 264–282; V=0 otherwise.
- EAV/SAV bytes: 0xFF, 0x00, 0x00, XY.
  - XY = {1, F, V, H, V^H, F^H, F^V, F^V^H}. H=1 for EAV, H=0 for SAV.
  - Resulting values: 0x80/0x9D, 0xAB/0xB6, 0xC7/0xDA, 0xEC/0xF1.
- HBLANK fill, and ACTIVE fill on V=1 lines: 0x80 at even `b`, 0x10 at odd `b`.
- ACTIVE on V=0 lines:
  - `px_req`=1 for each of the 1440 slots.
  - `data` = `px_data` captured on that edge.
- IDLE output: `data`=0x10, `px_req`=0.
- Reset values: state IDLE, `b`=0, `data`=0x10, `px_req`=0, `line_num`=1, `field`=1, `vblank`=1, `sof`=0, `led`=0.
- Reset mid-line aborts immediately. No residual `px_req` after the reset edge.

## Timing
- Slot `b` is decoded in cycle t; the byte appears on `data` in cycle t+1. Fixed latency: 1 clock.
- `px_req` is asserted in cycle t for active slot `b`, i.e. one cycle ahead of the byte appearing on `data`. The source must present valid `px_data` in that same cycle; no wait states are possible.
- `px_req` is high for exactly 1440 consecutive cycles per V=0 line and 0 on all other cycles.
- `line_num`, `field` and `vblank` update on the same edge that puts the EAV 0xFF on `data`.
- `sof` and the `led` toggle occur on the same edge as line 1 EAV 0xFF.
- From `en` 0→1 in IDLE, the first 0xFF appears on `data` 2 cycles later.
- Simultaneous `rst` and `en`: `rst` wins.

## Configuration
- `CCIR656_CLAMP_EN` defined:
  - Captured active bytes are clamped: 0x00 → 0x01, 0xFF → 0xFE.
  - Adds no latency.
- Undefined: `px_data` passes unmodified. The source is responsible for reserved codes.

## Test plan
- Reset, hold `en`=1 for one line on line 1.
  - `data` = FF 00 00 F1.
  - Then 268 bytes alternating 80/10.
  - Then FF 00 00 EC.
  - Then 1440 bytes of 80/10.
  - `px_req` never high.
- Run to line 20 with `px_data` = incrementing counter.
  - EAV XY=0x9D, SAV XY=0x80.
  - `px_req` high 1440 cycles.
  - `data` equals `px_data` delayed 1 cycle.
- Run a full frame.
  - Field-2 active lines give XY 0xDA/0xC7.
  - `line_num` wraps 525→1.
  - `sof` pulses once; `led` toggles.
- Drop `en` at line 30, b=500.
  - Line finishes at b=1715, then `data`=0x10 steady.
  - Re-raise `en`: line 1 EAV 0xFF appears 2 cycles later.
- Assert `rst` at line 40, b=800.
  - Next cycle: `px_req`=0, `data`=0x10, `line_num`=1.
- With `CCIR656_CLAMP_EN` defined, drive `px_data`=0xFF then 0x00 on line 20.
  - `data`=0xFE then 0x01.
  - Without the macro: `data`=0xFF then 0x00.
